// File: rtl/pcs_audio_pkg.sv
// Shared constants, field positions, FSM states and checksum helper
// for the PCS audio depacketiser.
package pcs_audio_pkg;

   localparam logic [15:0] HDR_SYNC = 16'hA55A;
   localparam logic [15:0] TRL_SYNC = 16'h5AA5;

   localparam int SYNC_MSB = 63;
   localparam int SYNC_LSB = 48;
   localparam int ID_MSB   = 47;
   localparam int ID_LSB   = 40;
   localparam int LEN_MSB  = 39;
   localparam int LEN_LSB  = 32;
   localparam int SEQ_MSB  = 31;
   localparam int SEQ_LSB  = 0;
   localparam int CSUM_MSB = 15;
   localparam int CSUM_LSB = 0;

   typedef enum logic [2:0] {
      IDLE,
      SKIP,
      PAYLOAD,
      TRAILER,
      DRAIN
   } state_t;

   function automatic logic [15:0] lane_sum(
      input logic [15:0] acc,
      input logic [63:0] w
   );
      return acc + w[15:0] + w[31:16] + w[47:32] + w[63:48];
   endfunction

endpackage

// File: rtl/pcs_audio_payload_buf.sv
// Payload store: MAX_WORDS x 64 RAM with independent write/read pointers.
// Pointers wrap naturally because MAX_WORDS is a power of two.
module pcs_audio_payload_buf #(
   parameter int MAX_WORDS = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_wr,
   input  logic [63:0] i_wdata,
   input  logic        i_rd,
   output logic [63:0] o_rdata
);

   localparam int AW = $clog2(MAX_WORDS);

   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [63:0]   r_mem [MAX_WORDS];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (i_clr) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (i_wr) r_wptr <= r_wptr + 1'b1;
         if (i_rd) r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_wr) r_mem[r_wptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rptr];

endmodule

// File: rtl/pcs_audio_depacket.sv
// PCS audio frame parser/validator feeding the unpack FIFO.
// Optional AUDIO_MUTE_ON_ERR_EN: failed frames drain as N zero words.
module pcs_audio_depacket #(
   parameter logic [7:0] CH_ID     = 8'h00,
   parameter int         MAX_WORDS = 16,
   parameter int         CNT_W     = 16
) (
   input  logic             i_pcs_clk,
   input  logic             i_rst,
   input  logic             i_pcs_valid,
   input  logic [63:0]      i_pcs_data,
   input  logic             i_fifo_full,
   output logic             o_valid,
   output logic [63:0]      o_data,
   output logic             o_seq_err,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_ok_cnt,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic [CNT_W-1:0] o_drop_cnt
);

   import pcs_audio_pkg::*;

   localparam logic [8:0] LEN_MAX = 9'(MAX_WORDS);

   state_t r_state;
   state_t w_next;

   logic [7:0]       r_len;
   logic [7:0]       r_cnt;
   logic [15:0]      r_csum;
   logic [31:0]      r_seq;
   logic [31:0]      r_last_seq;
   logic             r_seq_vld;
   logic             r_seq_err;
   logic             r_valid;
   logic [63:0]      r_data;
   logic [CNT_W-1:0] r_ok;
   logic [CNT_W-1:0] r_err;
   logic [CNT_W-1:0] r_drop;

   logic        w_is_hdr;
   logic [7:0]  w_id;
   logic [7:0]  w_len;
   logic [31:0] w_seq;
   logic        w_len_ok;
   logic        w_trl_ok;
   logic        w_take;
   logic        w_last;
   logic        w_clr;
   logic        w_wr;
   logic        w_rd;
   logic        w_accept;
   logic        w_ok_inc;
   logic        w_err_inc;
   logic        w_drop_inc;
   logic [63:0] w_rdata;
   logic [63:0] w_fill;

   assign w_id    = i_pcs_data[ID_MSB:ID_LSB];
   assign w_len   = i_pcs_data[LEN_MSB:LEN_LSB];
   assign w_seq   = i_pcs_data[SEQ_MSB:SEQ_LSB];
   assign w_is_hdr = i_pcs_valid
                  && (i_pcs_data[SYNC_MSB:SYNC_LSB] == HDR_SYNC);
   assign w_len_ok = (w_len != 8'd0) && ({1'b0, w_len} <= LEN_MAX);
   assign w_trl_ok = (i_pcs_data[SYNC_MSB:SYNC_LSB] == TRL_SYNC)
                  && (i_pcs_data[CSUM_MSB:CSUM_LSB] == r_csum);
   // A buffered word leaves only when the FIFO can take it.
   assign w_take = r_valid && !i_fifo_full;
   assign w_last = (r_cnt == r_len - 8'd1);

`ifdef AUDIO_MUTE_ON_ERR_EN
   logic r_mute;
   logic w_zero;
   assign w_zero = (r_state == TRAILER) ? !w_trl_ok : r_mute;
   assign w_fill = w_zero ? 64'h0 : w_rdata;
`else
   assign w_fill = w_rdata;
`endif

   pcs_audio_payload_buf #(
      .MAX_WORDS(MAX_WORDS)
   ) u_buf (
      .i_clk  (i_pcs_clk),
      .i_rst  (i_rst),
      .i_clr  (w_clr),
      .i_wr   (w_wr),
      .i_wdata(i_pcs_data),
      .i_rd   (w_rd),
      .o_rdata(w_rdata)
   );

   always_ff @(posedge i_pcs_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_clr      = 1'b0;
      w_wr       = 1'b0;
      w_rd       = 1'b0;
      w_accept   = 1'b0;
      w_ok_inc   = 1'b0;
      w_err_inc  = 1'b0;
      w_drop_inc = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_is_hdr) begin
               if (w_id != CH_ID) begin
                  w_next = SKIP;
               end else if (w_len_ok) begin
                  w_next = PAYLOAD;
                  w_clr  = 1'b1;
               end else begin
                  w_err_inc = 1'b1;
               end
            end
         end
         SKIP: begin
            if (i_pcs_valid && (r_cnt == r_len)) w_next = IDLE;
         end
         PAYLOAD: begin
            if (i_pcs_valid) begin
               w_wr = 1'b1;
               if (r_cnt == r_len - 8'd1) w_next = TRAILER;
            end
         end
         TRAILER: begin
            if (i_pcs_valid) begin
               if (w_trl_ok) begin
                  w_next   = DRAIN;
                  w_rd     = 1'b1;
                  w_accept = 1'b1;
                  w_ok_inc = 1'b1;
               end else begin
                  w_err_inc = 1'b1;
`ifdef AUDIO_MUTE_ON_ERR_EN
                  w_next = DRAIN;
                  w_rd   = 1'b1;
`else
                  w_next = IDLE;
`endif
               end
            end
         end
         DRAIN: begin
            if (w_take) begin
               if (w_last) w_next = IDLE;
               else        w_rd   = 1'b1;
            end
            if (w_is_hdr) w_drop_inc = 1'b1;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_pcs_clk or posedge i_rst) begin
      if (i_rst) begin
         r_len      <= '0;
         r_cnt      <= '0;
         r_csum     <= '0;
         r_seq      <= '0;
         r_last_seq <= '0;
         r_seq_vld  <= 1'b0;
         r_seq_err  <= 1'b0;
         r_valid    <= 1'b0;
         r_data     <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_is_hdr) begin
                  r_len  <= w_len;
                  r_seq  <= w_seq;
                  r_cnt  <= '0;
                  r_csum <= '0;
               end
            end
            SKIP: begin
               if (i_pcs_valid) r_cnt <= r_cnt + 8'd1;
            end
            PAYLOAD: begin
               if (i_pcs_valid) begin
                  r_cnt  <= r_cnt + 8'd1;
                  r_csum <= lane_sum(r_csum, i_pcs_data);
               end
            end
            TRAILER: begin
               if (i_pcs_valid) r_cnt <= '0;
            end
            DRAIN: begin
               if (w_take) r_cnt <= r_cnt + 8'd1;
            end
            default: ;
         endcase

         if (r_state == TRAILER && w_next == DRAIN)
            r_valid <= 1'b1;
         else if (r_state == DRAIN && w_take && w_last)
            r_valid <= 1'b0;
         if (w_rd) r_data <= w_fill;

         // First good frame after reset only seeds the history.
         r_seq_err <= w_accept && r_seq_vld
                   && (r_seq != r_last_seq + 32'd1);
         if (w_accept) begin
            r_last_seq <= r_seq;
            r_seq_vld  <= 1'b1;
         end
      end
   end

`ifdef AUDIO_MUTE_ON_ERR_EN
   always_ff @(posedge i_pcs_clk or posedge i_rst) begin
      if (i_rst)
         r_mute <= 1'b0;
      else if (r_state == TRAILER && i_pcs_valid)
         r_mute <= !w_trl_ok;
   end
`endif

   always_ff @(posedge i_pcs_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ok   <= '0;
         r_err  <= '0;
         r_drop <= '0;
      end else begin
         if (w_ok_inc && r_ok != '1)     r_ok   <= r_ok + 1'b1;
         if (w_err_inc && r_err != '1)   r_err  <= r_err + 1'b1;
         if (w_drop_inc && r_drop != '1) r_drop <= r_drop + 1'b1;
      end
   end

   assign o_valid    = r_valid && !i_fifo_full;
   assign o_data     = r_data;
   assign o_seq_err  = r_seq_err;
   assign o_busy     = (r_state != IDLE);
   assign o_ok_cnt   = r_ok;
   assign o_err_cnt  = r_err;
   assign o_drop_cnt = r_drop;

endmodule

// File: tb/tb_pcs_audio_depacket.sv
// Self-checking bench for pcs_audio_depacket: frame table plus
// hand sequences for back-pressure, drop-in-drain and mid-frame reset.
module tb_pcs_audio_depacket;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_pcs_valid;
   logic [63:0] i_pcs_data;
   logic        i_fifo_full;
   logic        o_valid;
   logic [63:0] o_data;
   logic        o_seq_err;
   logic        o_busy;
   logic [15:0] o_ok_cnt;
   logic [15:0] o_err_cnt;
   logic [15:0] o_drop_cnt;

   pcs_audio_depacket #(
      .CH_ID(8'h00), .MAX_WORDS(16), .CNT_W(16)
   ) dut (
      .i_pcs_clk  (clk),
      .i_rst      (i_rst),
      .i_pcs_valid(i_pcs_valid),
      .i_pcs_data (i_pcs_data),
      .i_fifo_full(i_fifo_full),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .o_seq_err  (o_seq_err),
      .o_busy     (o_busy),
      .o_ok_cnt   (o_ok_cnt),
      .o_err_cnt  (o_err_cnt),
      .o_drop_cnt (o_drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  id;
      logic [7:0]  n;
      logic [31:0] seq;
      logic [63:0] base;
      logic [15:0] bad;
      bit          hdr_only;
      bit          out;
      int          d_ok;
      int          d_err;
      int          pulses;
   } vec_t;

   vec_t        vt[12];
   logic [63:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          pulses = 0;
   int          exp_ok = 0;
   int          exp_err = 0;
   int          p0;
   int          mode;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] lsum(input logic [15:0] a,
                                        input logic [63:0] w);
      logic [31:0] s;
      s = 32'(a) + 32'(w[15:0]) + 32'(w[31:16])
        + 32'(w[47:32]) + 32'(w[63:48]);
      return s[15:0];
   endfunction

   always @(negedge clk) begin
      if (!i_rst) begin
         if (i_fifo_full) chk("full_gate", o_valid, 1'b0);
         if (o_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", o_data, 64'hX);
            end else begin
               chk("out_data", o_data, exp_q.pop_front());
            end
         end
         if (o_seq_err) pulses++;
      end
   end

   task automatic beat(input logic v, input logic [63:0] w);
      @(posedge clk);
      #1;
      i_pcs_valid = v;
      i_pcs_data  = w;
   endtask

   task automatic send_frame(input logic [7:0] id, input logic [7:0] n,
                             input logic [31:0] seq,
                             input logic [63:0] base,
                             input logic [15:0] bad, input int md);
      logic [15:0] cs;
      logic [63:0] w;
      cs = '0;
      beat(1'b1, {16'hA55A, id, n, seq});
      for (int k = 1; k <= int'(n); k++) begin
         w  = base + 64'(k);
         cs = lsum(cs, w);
         if (md == 1) exp_q.push_back(w);
         else if (md == 2) exp_q.push_back(64'h0);
         beat(1'b1, w);
      end
      beat(1'b1, {16'h5AA5, 32'h0, cs + bad});
   endtask

   task automatic wait_idle(input string nm);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         if (!o_busy && exp_q.size() == 0) done = 1'b1;
      end
      chk({nm, "_idle"}, 64'(done), 64'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      vt[0]  = '{8'h00, 8'd4,  32'd10, 64'd0, 16'd0, 0, 1, 1, 0, 0};
      vt[1]  = '{8'h00, 8'd4,  32'd10, 64'd0, 16'd1, 0, 0, 0, 1, 0};
      vt[2]  = '{8'h00, 8'd4,  32'd12, 64'd100, 16'd0, 0, 1, 1, 0, 1};
      vt[3]  = '{8'h00, 8'd3,  32'd13, 64'd40, 16'd0, 0, 1, 1, 0, 0};
      vt[4]  = '{8'h00, 8'd0,  32'd50, 64'd0, 16'd0, 1, 0, 0, 1, 0};
      vt[5]  = '{8'h00, 8'd17, 32'd51, 64'd0, 16'd0, 1, 0, 0, 1, 0};
      vt[6]  = '{8'h05, 8'd3,  32'd99, 64'hA55A_0004_0000_0000,
                 16'd0, 0, 0, 0, 0, 0};
      vt[7]  = '{8'h00, 8'd2,  32'd14, 64'd200, 16'd0, 0, 1, 1, 0, 0};
      vt[8]  = '{8'h00, 8'd16, 32'd15, 64'hA55A_0010_FFFF_FFF0,
                 16'd0, 0, 1, 1, 0, 0};
      vt[9]  = '{8'h00, 8'd1,  32'd20, 64'hFFFF_FFFF_FFFF_FFFE,
                 16'd0, 0, 1, 1, 0, 1};
      vt[10] = '{8'h00, 8'd2,  32'hFFFF_FFFF, 64'd5,
                 16'd0, 0, 1, 1, 0, 1};
      vt[11] = '{8'h00, 8'd3,  32'd0, 64'd9, 16'd0, 0, 1, 1, 0, 0};

      i_rst       = 1'b1;
      i_pcs_valid = 1'b0;
      i_pcs_data  = '0;
      i_fifo_full = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_cnts", {o_ok_cnt, o_err_cnt, o_drop_cnt}, 64'd0);
      i_rst = 1'b0;

      foreach (vt[i]) begin
         p0 = pulses;
         if (vt[i].hdr_only) begin
            beat(1'b1, {16'hA55A, vt[i].id, vt[i].n, vt[i].seq});
            @(negedge clk);
            chk($sformatf("v%0d_no_busy", i), 64'(o_busy), 64'd0);
         end else begin
            mode = vt[i].out ? 1 : 0;
`ifdef AUDIO_MUTE_ON_ERR_EN
            if (vt[i].bad != 16'd0) mode = 2;
`endif
            send_frame(vt[i].id, vt[i].n, vt[i].seq, vt[i].base,
                       vt[i].bad, mode);
         end
         beat(1'b0, 64'h0);
         wait_idle($sformatf("v%0d", i));
         exp_ok  += vt[i].d_ok;
         exp_err += vt[i].d_err;
         chk($sformatf("v%0d_ok", i), 64'(o_ok_cnt), 64'(exp_ok));
         chk($sformatf("v%0d_err", i), 64'(o_err_cnt), 64'(exp_err));
         chk($sformatf("v%0d_drop", i), 64'(o_drop_cnt), 64'd0);
         chk($sformatf("v%0d_seqerr", i), 64'(pulses - p0),
             64'(vt[i].pulses));
      end

      // Back-pressure in cycles 3-5 of the drain, header in cycle 2.
      p0 = pulses;
      send_frame(8'h00, 8'd8, 32'd1, 64'h1000, 16'd0, 1);
      for (int c = 1; c <= 14; c++) begin
         @(posedge clk);
         #1;
         i_pcs_valid = (c == 2);
         i_pcs_data  = (c == 2) ? {16'hA55A, 8'h00, 8'd2, 32'd2} : '0;
         i_fifo_full = (c >= 3 && c <= 5);
         if (c == 1) begin
            @(negedge clk);
            chk("drain_latency", 64'(o_valid), 64'd1);
         end
      end
      i_fifo_full = 1'b0;
      beat(1'b1, 64'd1);
      beat(1'b1, 64'd2);
      beat(1'b1, {16'h5AA5, 32'h0, 16'h0003});
      beat(1'b0, 64'h0);
      exp_ok++;
      wait_idle("bp");
      chk("bp_ok", 64'(o_ok_cnt), 64'(exp_ok));
      chk("bp_err", 64'(o_err_cnt), 64'(exp_err));
      chk("bp_drop", 64'(o_drop_cnt), 64'd1);
      chk("bp_seqerr", 64'(pulses - p0), 64'd0);

      // Reset in the middle of payload word 2 of 4.
      beat(1'b1, {16'hA55A, 8'h00, 8'd4, 32'd30});
      beat(1'b1, 64'd1);
      beat(1'b1, 64'd2);
      #2;
      i_rst = 1'b1;
      #1;
      exp_q.delete();
      chk("arst_valid", 64'(o_valid), 64'd0);
      chk("arst_busy", 64'(o_busy), 64'd0);
      chk("arst_cnts", {o_ok_cnt, o_err_cnt, o_drop_cnt}, 64'd0);
      @(posedge clk);
      #1;
      i_rst       = 1'b0;
      i_pcs_valid = 1'b0;
      p0 = pulses;
      send_frame(8'h00, 8'd4, 32'd40, 64'h50, 16'd0, 1);
      beat(1'b0, 64'h0);
      wait_idle("post_rst");
      chk("post_rst_ok", 64'(o_ok_cnt), 64'd1);
      chk("post_rst_err", 64'(o_err_cnt), 64'd0);
      chk("post_rst_seqerr", 64'(pulses - p0), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
